dct_transpose_buf: RTL and testbench
====================================

# dct_transpose_buf

Ping-pong 4x4 transpose buffer for the 2D DCT datapath. It sits directly downstream of the 36-bit, 4-deep multiplier-product FIFO. It drains row-pass results from that FIFO in row-major order and stores each 16-word block in one of two banks. It then streams the block out in column-major order, over a valid/ready handshake, to the column-pass stage.

## Interface
Parameters:
- DW, 36, data width; matches the FIFO word.
- N, 4, block dimension; the block is N×N words and N is a power of two. Only N=4 is verified.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_rd_en  output  1  read strobe to the upstream FIFO.
- fifo_dout  input  DW  upstream FIFO data; valid on the cycle after fifo_rd_en.
- out_data  output  DW  transposed word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  marks the final word (index N*N-1) of a block; qualified by out_valid.
- bank_full  output  2  per-bank "block complete, not yet drained" flags.

## Operation
- Storage: mem[2][N*N] of DW bits, no reset.
- Write-side state: wr_bank (1b), wr_idx (log2(N*N) b), rd_pending (1b).
- Read-side state: rd_bank (1b), rd_idx (log2(N*N) b).
- Read issue rule: fifo_rd_en=1 only when all of the following hold:
  - fifo_empty=0
  - rd_pending=0
  - fifo_rd_en was 0 in the previous cycle
  - bank_full[wr_bank]=0
- Consequences of the issue rule:
  - There are never two consecutive read strobes.
  - At most one read is in flight, which tolerates a one-cycle-late empty flag.
- Capture: on the cycle after fifo_rd_en (rd_pending=1), write fifo_dout into mem[wr_bank][wr_idx], then wr_idx+1.
- Block completion: when capture occurs with wr_idx=N*N-1:
  - set bank_full[wr_bank]
  - toggle wr_bank
  - wr_idx wraps to 0
- Drain:
  - When bank_full[rd_bank]=1 and (out_valid=0 or out_ready=1), load out_data from mem[rd_bank][(rd_idx mod N)*N + rd_idx/N] and set out_valid.
  - out_last is set when loading rd_idx=N*N-1.
  - Then rd_idx+1.
- Release: when the last word is accepted (out_valid & out_ready & out_last):
  - clear bank_full[rd_bank]
  - toggle rd_bank
  - rd_idx wraps to 0
- If no new load occurs on that cycle (the next bank is not full), out_valid drops to 0.
- Simultaneous set/clear: set targets wr_bank and clear targets rd_bank, so the two always address different banks. Both take effect in the same cycle.
- Both banks full: reads stall (fifo_rd_en=0) until a bank is released. Any already-pending capture cannot occur in this state, because the issue rule blocks it.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and rd_idx hold.

## Timing
- Reset values (one edge with rst=1):
  - fifo_rd_en=0, out_valid=0, out_last=0, out_data=0, bank_full=2'b00
  - wr_bank=0, rd_bank=0, wr_idx=0, rd_idx=0, rd_pending=0
- Reset mid-operation:
  - All in-flight state is discarded, including partial blocks and a pending FIFO read.
  - A word returning from a read issued before reset is not captured.
- Input throughput: 1 word per 2 cycles maximum. One block takes 32 cycles minimum with the FIFO non-empty.
- Latency: the 16th word is captured at edge E. bank_full sets at E. out_valid with element 0 is high after edge E+1.
- Output throughput: 1 word/cycle with out_ready=1. A full bank drains in 16 cycles.
- Back-to-back blocks: no bubble at the bank switch if the other bank is already full when the last word is accepted.
- fifo_rd_en is a registered output.

## Test plan
- Single block:
  - Stimulus: FIFO supplies 0..15, out_ready=1.
  - Required: output sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15. out_last only on 15. bank_full returns to 00 afterward. fifo_rd_en is never high in two consecutive cycles.
- Backpressure:
  - Stimulus: same block, with out_ready=0 for 5 cycles while out_data=9.
  - Required: out_data=9 and out_valid=1 are held for all 5 cycles. Next accepted word is 13. No word is lost or duplicated.
- Ping-pong:
  - Stimulus: blocks 0..15 then 100..115, with out_ready=0 until both are written.
  - Required: bank_full=11 and fifo_rd_en stays 0 while the FIFO is non-empty. After out_ready=1, 32 contiguous outputs: first block transposed, then 100,104,108,112,101,…,115. No gap between the blocks.
- Empty FIFO:
  - Stimulus: fifo_empty=1 for 50 cycles after 7 words written.
  - Required: fifo_rd_en=0 throughout and out_valid=0. Resuming with 9 more words completes the block, and output begins with word 0.
- Reset mid-block:
  - Stimulus: assert rst for 1 cycle during the output of word 6, with a FIFO read pending.
  - Required: on the next cycle out_valid=0 and bank_full=00, and the returning word is ignored. The next block 200..215 emerges as 200,204,….

Source files
------------

// File: rtl/dct_transpose_buf.sv
// rtl/dct_transpose_buf.sv - ping-pong NxN transpose buffer between the row-pass FIFO and the column pass
// Row-major words are captured into one bank while the other streams out column-major.
module dct_transpose_buf #(
  parameter int DW = 36,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_dout,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [1:0]    bank_full
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int LN = $clog2(N);

  logic [DW-1:0] mem [2][NN];

  logic          wr_bank;
  logic [IW-1:0] wr_idx;
  logic          rd_pending;
  logic          rd_bank;
  logic [IW-1:0] rd_idx;

  logic          capture;
  logic          wr_done;
  logic          release_blk;
  logic          src_bank;
  logic          load;
  logic [IW-1:0] rd_addr;
  logic [1:0]    full_nxt;
  logic          wr_bank_nxt;
  logic          rd_en_nxt;

  always_comb begin
    capture     = rd_pending;
    wr_done     = capture && (wr_idx == IW'(NN - 1));
    release_blk = out_valid && out_ready && out_last;
    // On release the next load comes from the other bank, so back-to-back blocks see no bubble.
    src_bank    = release_blk ? ~rd_bank : rd_bank;
    load        = bank_full[src_bank] && (!out_valid || out_ready);
    rd_addr     = {rd_idx[LN-1:0], rd_idx[IW-1:LN]};

    full_nxt = bank_full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (release_blk) full_nxt[rd_bank] = 1'b0;
    wr_bank_nxt = wr_bank ^ wr_done;

    // Current fifo_rd_en becomes next cycle's rd_pending; gating on it keeps one read in flight.
    rd_en_nxt = !fifo_empty && !fifo_rd_en && !full_nxt[wr_bank_nxt];
  end

  always_ff @(posedge clk) begin
    if (capture && !rst) mem[wr_bank][wr_idx] <= fifo_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_rd_en <= 1'b0;
      rd_pending <= 1'b0;
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      bank_full  <= 2'b00;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      fifo_rd_en <= rd_en_nxt;
      rd_pending <= fifo_rd_en;
      wr_bank    <= wr_bank_nxt;
      bank_full  <= full_nxt;
      if (capture) wr_idx <= wr_idx + IW'(1);
      if (release_blk) rd_bank <= ~rd_bank;
      if (load) begin
        out_data  <= mem[src_bank][rd_addr];
        out_valid <= 1'b1;
        out_last  <= (rd_idx == IW'(NN - 1));
        rd_idx    <= rd_idx + IW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// tb/tb_dct_transpose_buf.sv - scoreboard bench for dct_transpose_buf
module tb_dct_transpose_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [35:0] fifo_dout = '0;
  logic [35:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [1:0]  bank_full;

  typedef struct {
    logic [35:0] d;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [35:0] fq[$];
  int          errors = 0;
  int          checks = 0;
  logic        prev_rd_en = 1'b0;

  dct_transpose_buf #(.DW(36), .N(4)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
  end

  always @(negedge clk) fifo_empty = (fq.size() == 0);

  // Monitor: compare every accepted word against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_rd_en = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        checks++;
        if (prev_rd_en) begin
          errors++;
          $display("FAIL rd_en_back_to_back: got two consecutive strobes, required none");
        end
      end
      prev_rd_en = fifo_rd_en;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %0d, required no output", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            errors++;
            $display("FAIL out_word: got data=%0d last=%0b, required data=%0d last=%0b",
                     out_data, out_last, e.d, e.l);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic expect_block(input int base);
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.d = 36'(base + (i % 4) * 4 + i / 4);
      e.l = (i == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic feed(input int base, input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) fq.push_back(36'(base + i));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 36'(exp_q.size()), 36'd0);
    tick();
  endtask

  initial begin
    int n;
    // Reset state
    rst = 1'b1;
    tick();
    check("rst_rd_en", 36'(fifo_rd_en), 36'd0);
    check("rst_valid", 36'(out_valid), 36'd0);
    check("rst_last", 36'(out_last), 36'd0);
    check("rst_data", out_data, 36'd0);
    check("rst_bank_full", 36'(bank_full), 36'd0);
    rst = 1'b0;

    // Single block
    out_ready = 1'b1;
    expect_block(0);
    feed(0, 0, 16);
    wait_drain("single", 200);
    check("single_bank_full", 36'(bank_full), 36'd0);

    // Backpressure on word 9
    expect_block(0);
    feed(0, 0, 16);
    n = 0;
    while (!(out_valid && out_data == 36'd9) && n < 200) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("bp_reached_9", 36'(out_valid && out_data == 36'd9), 36'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", out_data, 36'd9);
      check("bp_hold_valid", 36'(out_valid), 36'd1);
    end
    out_ready = 1'b1;
    wait_drain("bp", 200);

    // Ping-pong: both banks fill, extra block stays in the FIFO
    out_ready = 1'b0;
    expect_block(0);
    expect_block(100);
    expect_block(300);
    feed(0, 0, 16);
    feed(100, 0, 16);
    feed(300, 0, 16);
    n = 0;
    while (bank_full != 2'b11 && n < 300) begin
      tick();
      n++;
    end
    check("pp_bank_full", 36'(bank_full), 36'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pp_stall_rd_en", 36'(fifo_rd_en), 36'd0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("pp_contiguous", 36'(out_valid), 36'd1);
    end
    wait_drain("pp", 300);

    // Empty FIFO after 7 words
    expect_block(0);
    feed(0, 0, 7);
    repeat (20) tick();
    for (int i = 0; i < 50; i++) begin
      tick();
      check("empty_rd_en_valid", 36'({fifo_rd_en, out_valid}), 36'd0);
    end
    feed(0, 7, 9);
    wait_drain("empty", 200);

    // Reset while word 6 is presented and a FIFO read is outstanding
    out_ready = 1'b1;
    expect_block(500);
    feed(500, 0, 16);
    feed(600, 0, 16);
    n = 0;
    while (!(out_valid && out_data == 36'd509) && n < 200) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("rst_mid_word6", out_data, 36'd509);
    n = 0;
    while (!fifo_rd_en && n < 20) begin
      tick();
      n++;
    end
    check("rst_mid_read_pending", 36'(fifo_rd_en), 36'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    fq.delete();
    rst = 1'b0;
    check("rst_mid_valid", 36'(out_valid), 36'd0);
    check("rst_mid_bank_full", 36'(bank_full), 36'd0);
    out_ready = 1'b1;
    expect_block(200);
    feed(200, 0, 16);
    wait_drain("after_rst", 200);
    check("final_bank_full", 36'(bank_full), 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
